// File: rtl/usart_tx_framed_if.sv
// Word handshake between the UART register block and the framed transmitter.
interface usart_tx_framed_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data_in;
  logic                 valid_in;
  logic                 ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/usart_tx_framed.sv
// Framed USART TX: internal baud divider, 5..9 data bits, parity, 1/2 stop, one-word holding buffer.
// Accept-to-start 1 clock when idle; ready_out low while holding full; USART_TX_BREAK_EN adds break_in.
module usart_tx_framed #(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  usart_tx_framed_if.slave     s_in,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [1:0]           parity_mode,
  input  logic                 stop_two,
`ifdef USART_TX_BREAK_EN
  input  logic                 break_in,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 tx_pin
);

  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS);

`ifdef USART_TX_BREAK_EN
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;
`endif

  state_t               r_state, w_state_n;
  logic [DIV_WIDTH-1:0] r_cnt, w_cnt_n, r_div, w_div_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic [IW-1:0]        r_idx, w_idx_n;
  logic                 r_par, w_par_n, r_par_en, w_par_en_n;
  logic                 r_stop_two, w_stop_two_n, r_stop_cnt, w_stop_cnt_n;
  logic                 r_tx, w_tx_n, r_done, w_done_n;
  logic                 r_hold_vld, r_hold_st;
  logic [DATA_BITS-1:0] r_hold_dat;
  logic [1:0]           r_hold_pm;
  logic                 w_tick, w_load, w_accept, w_brk_req;
`ifdef USART_TX_BREAK_EN
  logic                 r_brk_rec, w_brk_rec_n;
  assign w_brk_req = break_in;
`else
  assign w_brk_req = 1'b0;
`endif

  function automatic logic par_of(input logic [1:0] pm, input logic [DATA_BITS-1:0] d);
    case (pm)
      2'b01:   return ~^d;
      2'b10:   return ^d;
      2'b11:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign w_tick      = (r_cnt == '0);
  assign w_accept    = s_in.valid_in && !r_hold_vld;
  assign s_in.ready_out = !r_hold_vld;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign tx_pin      = r_tx;

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_div_n      = r_div;
    w_shift_n    = r_shift;
    w_idx_n      = r_idx;
    w_par_n      = r_par;
    w_par_en_n   = r_par_en;
    w_stop_two_n = r_stop_two;
    w_stop_cnt_n = r_stop_cnt;
    w_tx_n       = r_tx;
    w_done_n     = 1'b0;
    w_load       = 1'b0;
`ifdef USART_TX_BREAK_EN
    w_brk_rec_n  = r_brk_rec;
`endif
    case (r_state)
      S_IDLE: begin
        w_tx_n = 1'b1;
`ifdef USART_TX_BREAK_EN
        if (break_in) begin
          w_state_n   = S_BREAK;
          w_tx_n      = 1'b0;
          w_brk_rec_n = 1'b0;
        end else
`endif
        if (r_hold_vld) w_load = 1'b1;
      end
      S_DATA: begin
        w_cnt_n = r_cnt - 1'b1;
        if (w_tick) begin
          w_cnt_n = r_div;
          if (r_idx == LAST_IDX) begin
            if (r_par_en) begin
              w_state_n = S_PARITY;
              w_tx_n    = r_par;
            end else begin
              w_state_n    = S_STOP;
              w_tx_n       = 1'b1;
              w_stop_cnt_n = 1'b0;
            end
          end else begin
            w_tx_n    = r_shift[0];
            w_shift_n = {1'b0, r_shift[DATA_BITS-1:1]};
            w_idx_n   = r_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        w_cnt_n = r_cnt - 1'b1;
        if (w_tick) begin
          w_cnt_n      = r_div;
          w_state_n    = S_STOP;
          w_tx_n       = 1'b1;
          w_stop_cnt_n = 1'b0;
        end
      end
      S_STOP: begin
        w_cnt_n = r_cnt - 1'b1;
        if (w_tick) begin
          w_cnt_n = r_div;
          if (r_stop_two && !r_stop_cnt) begin
            w_stop_cnt_n = 1'b1;
          end else begin
            // A pending break outranks a queued word; it starts from IDLE next clock.
            w_done_n  = 1'b1;
            w_state_n = S_IDLE;
            w_tx_n    = 1'b1;
            if (r_hold_vld && !w_brk_req) w_load = 1'b1;
          end
        end
      end
`ifdef USART_TX_BREAK_EN
      S_BREAK: begin
        if (!r_brk_rec) begin
          if (!break_in) begin
            w_brk_rec_n = 1'b1;
            w_tx_n      = 1'b1;
            w_cnt_n     = divisor;
          end
        end else if (w_tick) begin
          w_state_n = S_IDLE;
          w_tx_n    = 1'b1;
          if (r_hold_vld) w_load = 1'b1;
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end
`endif
      default: w_state_n = S_IDLE;
    endcase
    if (w_load) begin
      w_state_n    = S_DATA;
      w_tx_n       = 1'b0;
      w_cnt_n      = divisor;
      w_div_n      = divisor;
      w_shift_n    = r_hold_dat;
      w_idx_n      = '0;
      w_par_n      = par_of(r_hold_pm, r_hold_dat);
      w_par_en_n   = (r_hold_pm != 2'b00);
      w_stop_two_n = r_hold_st;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_div      <= '0;
      r_shift    <= '0;
      r_idx      <= '0;
      r_par      <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop_two <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
      r_hold_vld <= 1'b0;
      r_hold_dat <= '0;
      r_hold_pm  <= 2'b00;
      r_hold_st  <= 1'b0;
`ifdef USART_TX_BREAK_EN
      r_brk_rec  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_div      <= w_div_n;
      r_shift    <= w_shift_n;
      r_idx      <= w_idx_n;
      r_par      <= w_par_n;
      r_par_en   <= w_par_en_n;
      r_stop_two <= w_stop_two_n;
      r_stop_cnt <= w_stop_cnt_n;
      r_tx       <= w_tx_n;
      r_done     <= w_done_n;
`ifdef USART_TX_BREAK_EN
      r_brk_rec  <= w_brk_rec_n;
`endif
      if (w_accept) begin
        r_hold_vld <= 1'b1;
        r_hold_dat <= s_in.data_in;
        r_hold_pm  <= parity_mode;
        r_hold_st  <= stop_two;
      end else if (w_load) begin
        r_hold_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usart_tx_framed.sv
// Directed bench for usart_tx_framed: an 8-bit and a 7-bit instance sharing clock, reset and line config.
module tb_usart_tx_framed;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] divisor = 16'd0;
  logic [1:0]  parity_mode = 2'b00;
  logic        stop_two = 1'b0;
  logic        break_in = 1'b0;
  logic        busy8, done8, tx8, busy7, done7, tx7;

  usart_tx_framed_if #(.DATA_BITS(8)) if8 ();
  usart_tx_framed_if #(.DATA_BITS(7)) if7 ();

  usart_tx_framed #(.DATA_BITS(8), .DIV_WIDTH(16)) dut8 (
    .clock(clock), .reset_n(reset_n), .s_in(if8), .divisor(divisor),
    .parity_mode(parity_mode), .stop_two(stop_two),
`ifdef USART_TX_BREAK_EN
    .break_in(break_in),
`endif
    .busy(busy8), .done(done8), .tx_pin(tx8));

  usart_tx_framed #(.DATA_BITS(7), .DIV_WIDTH(16)) dut7 (
    .clock(clock), .reset_n(reset_n), .s_in(if7), .divisor(divisor),
    .parity_mode(parity_mode), .stop_two(stop_two),
`ifdef USART_TX_BREAK_EN
    .break_in(1'b0),
`endif
    .busy(busy7), .done(done7), .tx_pin(tx7));

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [7:0] wq[$];
  logic cap_tx[0:127], cap_busy[0:127], cap_done[0:127], cap_rdy[0:127];
  int acc_idx[0:3];
  int n_acc;

  // Called at a negedge. cap[i] holds outputs after the (i+1)-th following posedge;
  // acc_idx records the i whose posedge accepted a word.
  task automatic run(input int sel, input int ncyc, input int brk_cyc);
    logic drv_v, rdy_now;
    n_acc = 0;
    for (int i = 0; i < ncyc; i++) begin
      drv_v = (wq.size() > 0);
      break_in = (i < brk_cyc);
      if (sel == 7) begin
        if7.valid_in = drv_v;
        if7.data_in  = drv_v ? wq[0][6:0] : 7'h00;
        rdy_now = if7.ready_out;
      end else begin
        if8.valid_in = drv_v;
        if8.data_in  = drv_v ? wq[0] : 8'h00;
        rdy_now = if8.ready_out;
      end
      @(negedge clock);
      if (drv_v && rdy_now) begin
        if (n_acc < 4) acc_idx[n_acc] = i;
        n_acc++;
        void'(wq.pop_front());
      end
      cap_tx[i]   = (sel == 7) ? tx7 : tx8;
      cap_busy[i] = (sel == 7) ? busy7 : busy8;
      cap_done[i] = (sel == 7) ? done7 : done8;
      cap_rdy[i]  = (sel == 7) ? if7.ready_out : if8.ready_out;
    end
    if8.valid_in = 1'b0;
    if7.valid_in = 1'b0;
    break_in = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    checks++; if (tx8 !== 1'b1) begin errors++; $display("FAIL reset_tx8: got %b want 1", tx8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %b want 0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done8: got %b want 0", done8); end
    checks++; if (if8.ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready8: got %b want 1", if8.ready_out); end
    checks++; if (tx7 !== 1'b1 || busy7 !== 1'b0 || if7.ready_out !== 1'b1) begin
      errors++; $display("FAIL reset_dut7: tx=%b busy=%b ready=%b want 1,0,1", tx7, busy7, if7.ready_out); end
    reset_n = 1'b1;
    run(8, 3, 0);
  endtask

  task automatic test_basic_8n1;
    logic [9:0] exp_f;
    exp_f = {1'b1, 8'hA5, 1'b0};
    divisor = 16'd3; parity_mode = 2'b00; stop_two = 1'b0;
    wq.push_back(8'hA5);
    run(8, 46, 0);
    checks++; if (cap_rdy[0] !== 1'b0 || cap_rdy[1] !== 1'b1) begin
      errors++; $display("FAIL a5_ready_pulse: got %b%b want 01", cap_rdy[0], cap_rdy[1]); end
    checks++; if (cap_tx[0] !== 1'b1 || cap_busy[0] !== 1'b0) begin
      errors++; $display("FAIL a5_latency: tx=%b busy=%b before start, want 1,0", cap_tx[0], cap_busy[0]); end
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (cap_tx[1+4*b+c] !== exp_f[b] || cap_busy[1+4*b+c] !== 1'b1) begin
          errors++; $display("FAIL a5_bit%0d_clk%0d: tx=%b busy=%b want %b,1", b, c, cap_tx[1+4*b+c], cap_busy[1+4*b+c], exp_f[b]); end
      end
    checks++; if (cap_done[40] !== 1'b0 || cap_done[41] !== 1'b1 || cap_done[42] !== 1'b0) begin
      errors++; $display("FAIL a5_done: got %b%b%b want 010", cap_done[40], cap_done[41], cap_done[42]); end
    checks++; if (cap_busy[41] !== 1'b0 || cap_tx[41] !== 1'b1) begin
      errors++; $display("FAIL a5_end_idle: busy=%b tx=%b want 0,1", cap_busy[41], cap_tx[41]); end
  endtask

  task automatic test_parity;
    logic [1:0] modes [0:2];
    logic       exp_p [0:2];
    modes[0] = 2'b10; exp_p[0] = 1'b1;
    modes[1] = 2'b01; exp_p[1] = 1'b0;
    modes[2] = 2'b11; exp_p[2] = 1'b1;
    divisor = 16'd0; stop_two = 1'b0;
    for (int m = 0; m < 3; m++) begin
      parity_mode = modes[m];
      wq.push_back(8'h07);
      run(8, 16, 0);
      checks++; if (cap_tx[10] !== exp_p[m]) begin
        errors++; $display("FAIL par_mode%0d_bit9: got %b want %b", modes[m], cap_tx[10], exp_p[m]); end
      checks++; if (cap_tx[11] !== 1'b1 || cap_busy[11] !== 1'b1 || cap_done[11] !== 1'b0) begin
        errors++; $display("FAIL par_mode%0d_stop: tx=%b busy=%b done=%b want 1,1,0", modes[m], cap_tx[11], cap_busy[11], cap_done[11]); end
      checks++; if (cap_done[12] !== 1'b1 || cap_busy[12] !== 1'b0) begin
        errors++; $display("FAIL par_mode%0d_len11: done=%b busy=%b want 1,0", modes[m], cap_done[12], cap_busy[12]); end
      checks++; if (cap_tx[1] !== 1'b0 || cap_tx[2] !== 1'b1 || cap_tx[9] !== 1'b0) begin
        errors++; $display("FAIL par_mode%0d_data: start=%b d0=%b d7=%b want 0,1,0", modes[m], cap_tx[1], cap_tx[2], cap_tx[9]); end
    end
  endtask

  task automatic test_seven_bit;
    logic [10:0] exp_f;
    exp_f = {2'b11, 1'b1, 7'h55, 1'b0};
    divisor = 16'd1; parity_mode = 2'b01; stop_two = 1'b1;
    wq.push_back(8'h55);
    run(7, 28, 0);
    for (int b = 0; b < 11; b++)
      for (int c = 0; c < 2; c++) begin
        checks++;
        if (cap_tx[1+2*b+c] !== exp_f[b]) begin
          errors++; $display("FAIL d7_bit%0d_clk%0d: tx=%b want %b", b, c, cap_tx[1+2*b+c], exp_f[b]); end
      end
    checks++; if (cap_done[22] !== 1'b0 || cap_busy[22] !== 1'b1 || cap_done[23] !== 1'b1 || cap_busy[23] !== 1'b0) begin
      errors++; $display("FAIL d7_done22: done=%b%b busy=%b%b want 01,10", cap_done[22], cap_done[23], cap_busy[22], cap_busy[23]); end
    stop_two = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [9:0] f1, f2;
    int nbusy, nrdy_hi;
    f1 = {1'b1, 8'h12, 1'b0};
    f2 = {1'b1, 8'h34, 1'b0};
    divisor = 16'd3; parity_mode = 2'b00; stop_two = 1'b0;
    wq.push_back(8'h12); wq.push_back(8'h34);
    run(8, 86, 0);
    checks++; if (n_acc !== 2 || acc_idx[0] !== 0 || acc_idx[1] !== 2) begin
      errors++; $display("FAIL b2b_accept: n=%0d at %0d,%0d want 2 at 0,2", n_acc, acc_idx[0], acc_idx[1]); end
    nrdy_hi = 0;
    for (int i = 2; i <= 40; i++) if (cap_rdy[i] !== 1'b0) nrdy_hi++;
    checks++; if (nrdy_hi !== 0 || cap_rdy[41] !== 1'b1) begin
      errors++; $display("FAIL b2b_ready: high %0d clocks in hold window, at start2=%b want 0,1", nrdy_hi, cap_rdy[41]); end
    checks++; if (cap_done[41] !== 1'b1 || cap_tx[41] !== 1'b0 || cap_busy[41] !== 1'b1) begin
      errors++; $display("FAIL b2b_nogap: done=%b tx=%b busy=%b want 1,0,1", cap_done[41], cap_tx[41], cap_busy[41]); end
    for (int b = 0; b < 10; b++) begin
      checks++; if (cap_tx[1+4*b] !== f1[b] || cap_tx[41+4*b+3] !== f2[b]) begin
        errors++; $display("FAIL b2b_bit%0d: f1=%b f2=%b want %b,%b", b, cap_tx[1+4*b], cap_tx[44+4*b], f1[b], f2[b]); end
    end
    nbusy = 0;
    for (int i = 0; i < 86; i++) if (cap_busy[i] === 1'b1) nbusy++;
    checks++; if (nbusy !== 80 || cap_done[81] !== 1'b1 || cap_busy[81] !== 1'b0) begin
      errors++; $display("FAIL b2b_busy80: busy=%0d done81=%b want 80,1", nbusy, cap_done[81]); end
  endtask

  task automatic test_reset_midframe;
    int nbad;
    divisor = 16'd3; parity_mode = 2'b00; stop_two = 1'b0;
    wq.push_back(8'hFF); wq.push_back(8'h81);
    run(8, 18, 0);
    checks++; if (cap_tx[17] !== 1'b1 || cap_busy[17] !== 1'b1 || cap_rdy[17] !== 1'b0) begin
      errors++; $display("FAIL rst_pre: tx=%b busy=%b ready=%b want 1,1,0", cap_tx[17], cap_busy[17], cap_rdy[17]); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (tx8 !== 1'b1 || busy8 !== 1'b0 || if8.ready_out !== 1'b1 || done8 !== 1'b0) begin
      errors++; $display("FAIL rst_async: tx=%b busy=%b ready=%b done=%b want 1,0,1,0", tx8, busy8, if8.ready_out, done8); end
    @(negedge clock);
    reset_n = 1'b1;
    run(8, 50, 0);
    nbad = 0;
    for (int i = 0; i < 50; i++) if (cap_tx[i] !== 1'b1 || cap_busy[i] !== 1'b0 || cap_done[i] !== 1'b0) nbad++;
    checks++; if (nbad !== 0) begin
      errors++; $display("FAIL rst_discard: %0d active clocks after reset want 0", nbad); end
  endtask

`ifdef USART_TX_BREAK_EN
  task automatic test_break;
    logic [9:0] f;
    int nlow, nrec, ndone;
    f = {1'b1, 8'h5A, 1'b0};
    divisor = 16'd3; parity_mode = 2'b00; stop_two = 1'b0;
    wq.push_back(8'h5A);
    run(8, 70, 20);
    nlow = 0; nrec = 0; ndone = 0;
    for (int i = 0; i < 20; i++) if (cap_tx[i] === 1'b0 && cap_busy[i] === 1'b1) nlow++;
    for (int i = 20; i < 24; i++) if (cap_tx[i] === 1'b1 && cap_busy[i] === 1'b1) nrec++;
    for (int i = 0; i < 64; i++) if (cap_done[i] === 1'b1) ndone++;
    checks++; if (nlow !== 20) begin errors++; $display("FAIL brk_low: %0d clocks want 20", nlow); end
    checks++; if (nrec !== 4) begin errors++; $display("FAIL brk_mark: %0d clocks want 4", nrec); end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL brk_nodone: %0d pulses want 0", ndone); end
    checks++; if (cap_rdy[23] !== 1'b0 || cap_rdy[24] !== 1'b1) begin
      errors++; $display("FAIL brk_hold: ready=%b%b want 01", cap_rdy[23], cap_rdy[24]); end
    for (int b = 0; b < 10; b++) begin
      checks++; if (cap_tx[24+4*b] !== f[b]) begin
        errors++; $display("FAIL brk_5a_bit%0d: got %b want %b", b, cap_tx[24+4*b], f[b]); end
    end
    checks++; if (cap_done[64] !== 1'b1) begin errors++; $display("FAIL brk_5a_done: got %b want 1", cap_done[64]); end
  endtask
`endif

  initial begin
    if8.valid_in = 1'b0; if8.data_in = 8'h00;
    if7.valid_in = 1'b0; if7.data_in = 7'h00;
    test_reset();
    test_basic_8n1();
    test_parity();
    test_seven_bit();
    test_back_to_back();
    test_reset_midframe();
`ifdef USART_TX_BREAK_EN
    test_break();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
